// File: rtl/alu_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_checker
// Purpose  : Two-stage response checker for the W-bit alu; recomputes the
//            golden {co,z}, compares, counts and captures the first failure.
// Revision : 1.0
// ============================================================================
module alu_checker #(
  parameter int W  = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          s0,
  input  logic          s1,
  input  logic          s2,
  input  logic          ci,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [W-1:0]  z,
  input  logic          co,
  input  logic          clear,
  output logic          chk_valid,
  output logic          chk_fail,
  output logic [CW-1:0] pass_cnt,
  output logic [CW-1:0] fail_cnt,
  output logic          err,
  output logic [2:0]    fail_op,
  output logic [W-1:0]  fail_a,
  output logic [W-1:0]  fail_b,
  output logic          fail_ci,
  output logic [W:0]    fail_exp,
  output logic [W:0]    fail_got
);

  localparam logic [CW-1:0] c_cnt_max = '1;
  localparam logic [CW-1:0] c_cnt_one = {{(CW-1){1'b0}}, 1'b1};

  logic          r_s1_valid;
  logic [2:0]    r_s1_op;
  logic [W-1:0]  r_s1_a;
  logic [W-1:0]  r_s1_b;
  logic          r_s1_ci;
  logic [W:0]    r_s1_got;

  logic          r_chk_valid;
  logic          r_chk_fail;
  logic [CW-1:0] r_pass_cnt;
  logic [CW-1:0] r_fail_cnt;
  logic          r_err;
  logic [2:0]    r_fail_op;
  logic [W-1:0]  r_fail_a;
  logic [W-1:0]  r_fail_b;
  logic          r_fail_ci;
  logic [W:0]    r_fail_exp;
  logic [W:0]    r_fail_got;

  logic [W:0]    w_a_ext;
  logic [W:0]    w_b_ext;
  logic [W:0]    w_nb_ext;
  logic [W:0]    w_ci_ext;
  logic [W:0]    w_exp;
  logic          w_mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_ci    <= 1'b0;
      r_s1_got   <= '0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op  <= {s2, s1, s0};
        r_s1_a   <= a;
        r_s1_b   <= b;
        r_s1_ci  <= ci;
        r_s1_got <= {co, z};
      end
    end
  end

  // Golden model: all arithmetic carried in W+1 bits so bit W is the carry-out.
  assign w_a_ext  = {1'b0, r_s1_a};
  assign w_b_ext  = {1'b0, r_s1_b};
  assign w_nb_ext = {1'b0, ~r_s1_b};
  assign w_ci_ext = {{W{1'b0}}, r_s1_ci};

  always_comb begin
    w_exp = '0;
    case (r_s1_op)
      3'b000: w_exp = {1'b0, r_s1_a & r_s1_b};
      3'b001: w_exp = {1'b0, r_s1_a | r_s1_b};
      3'b010: w_exp = {1'b0, r_s1_a ^ r_s1_b};
      3'b011: w_exp = w_a_ext + w_b_ext + w_ci_ext;
      3'b100: w_exp = {1'b0, ~r_s1_a};
      3'b101: w_exp = w_a_ext + w_nb_ext + w_ci_ext;
      3'b110: w_exp = w_a_ext;
      3'b111: w_exp = w_a_ext + w_ci_ext;
      default: w_exp = '0;
    endcase
  end

  assign w_mismatch = (w_exp != r_s1_got);

  // clear wins over the comparison completing on the same edge: the pulse
  // still goes out but the result is neither counted nor captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chk_valid <= 1'b0;
      r_chk_fail  <= 1'b0;
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_err       <= 1'b0;
      r_fail_op   <= '0;
      r_fail_a    <= '0;
      r_fail_b    <= '0;
      r_fail_ci   <= 1'b0;
      r_fail_exp  <= '0;
      r_fail_got  <= '0;
    end else begin
      r_chk_valid <= r_s1_valid;
      r_chk_fail  <= r_s1_valid & w_mismatch;
      if (clear) begin
        r_pass_cnt <= '0;
        r_fail_cnt <= '0;
        r_err      <= 1'b0;
        r_fail_op  <= '0;
        r_fail_a   <= '0;
        r_fail_b   <= '0;
        r_fail_ci  <= 1'b0;
        r_fail_exp <= '0;
        r_fail_got <= '0;
      end else if (r_s1_valid) begin
        if (w_mismatch) begin
          if (r_fail_cnt != c_cnt_max) begin
            r_fail_cnt <= r_fail_cnt + c_cnt_one;
          end
          r_err <= 1'b1;
          if (!r_err) begin
            r_fail_op  <= r_s1_op;
            r_fail_a   <= r_s1_a;
            r_fail_b   <= r_s1_b;
            r_fail_ci  <= r_s1_ci;
            r_fail_exp <= w_exp;
            r_fail_got <= r_s1_got;
          end
        end else if (r_pass_cnt != c_cnt_max) begin
          r_pass_cnt <= r_pass_cnt + c_cnt_one;
        end
      end
    end
  end

  assign chk_valid = r_chk_valid;
  assign chk_fail  = r_chk_fail;
  assign pass_cnt  = r_pass_cnt;
  assign fail_cnt  = r_fail_cnt;
  assign err       = r_err;
  assign fail_op   = r_fail_op;
  assign fail_a    = r_fail_a;
  assign fail_b    = r_fail_b;
  assign fail_ci   = r_fail_ci;
  assign fail_exp  = r_fail_exp;
  assign fail_got  = r_fail_got;

endmodule
`default_nettype wire

// File: tb/tb_alu_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_checker
// Purpose  : Directed scoreboard bench for alu_checker (W=4; CW=16 and CW=2).
// Revision : 1.0
// ============================================================================
module tb_alu_checker;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       s0, s1, s2, ci, co, clear;
  logic [3:0] a, b, z;

  logic        chk_valid, chk_fail, err, fail_ci;
  logic [15:0] pass_cnt, fail_cnt;
  logic [2:0]  fail_op;
  logic [3:0]  fail_a, fail_b;
  logic [4:0]  fail_exp, fail_got;

  logic        sat_chk_valid, sat_chk_fail, sat_err, sat_fail_ci;
  logic [1:0]  sat_pass_cnt, sat_fail_cnt;
  logic [2:0]  sat_fail_op;
  logic [3:0]  sat_fail_a, sat_fail_b;
  logic [4:0]  sat_fail_exp, sat_fail_got;

  alu_checker #(.W(4), .CW(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .s0(s0), .s1(s1), .s2(s2), .ci(ci), .a(a), .b(b), .z(z), .co(co),
    .clear(clear),
    .chk_valid(chk_valid), .chk_fail(chk_fail),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err(err),
    .fail_op(fail_op), .fail_a(fail_a), .fail_b(fail_b), .fail_ci(fail_ci),
    .fail_exp(fail_exp), .fail_got(fail_got)
  );

  alu_checker #(.W(4), .CW(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .s0(s0), .s1(s1), .s2(s2), .ci(ci), .a(a), .b(b), .z(z), .co(co),
    .clear(clear),
    .chk_valid(sat_chk_valid), .chk_fail(sat_chk_fail),
    .pass_cnt(sat_pass_cnt), .fail_cnt(sat_fail_cnt), .err(sat_err),
    .fail_op(sat_fail_op), .fail_a(sat_fail_a), .fail_b(sat_fail_b),
    .fail_ci(sat_fail_ci), .fail_exp(sat_fail_exp), .fail_got(sat_fail_got)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   due;
    logic fail;
  } exp_t;
  exp_t sb[$];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] alu_ref(input logic [2:0] op, input logic [3:0] x,
                                         input logic [3:0] y, input logic c);
    logic [4:0] xe, ye, nye, ce;
    xe  = {1'b0, x};
    ye  = {1'b0, y};
    nye = {1'b0, ~y};
    ce  = {4'b0, c};
    case (op)
      3'd0:    return {1'b0, x & y};
      3'd1:    return {1'b0, x | y};
      3'd2:    return {1'b0, x ^ y};
      3'd3:    return xe + ye + ce;
      3'd4:    return {1'b0, ~x};
      3'd5:    return xe + nye + ce;
      3'd6:    return xe;
      default: return xe + ce;
    endcase
  endfunction

  // One cycle of stimulus; a valid transaction queues its expected verdict,
  // due two cycles after the cycle it is presented in.
  task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] ta,
                       input logic [3:0] tb_, input logic tci, input logic [4:0] got,
                       input logic clr);
    exp_t e;
    in_valid = v;
    {s2, s1, s0} = op;
    a = ta;
    b = tb_;
    ci = tci;
    {co, z} = got;
    clear = clr;
    if (v) begin
      e.due  = cyc + 2;
      e.fail = (got !== alu_ref(op, ta, tb_, tci));
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic clr);
    for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 5'd0, clr);
  endtask

  task automatic ok(input logic [2:0] op, input logic [3:0] ta, input logic [3:0] tb_,
                    input logic tci, input logic clr);
    drive(1'b1, op, ta, tb_, tci, alu_ref(op, ta, tb_, tci), clr);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (chk_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_chk_valid", 64'(chk_valid), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("chk_latency", 64'(cyc), 64'(e.due));
          check("chk_fail", 64'(chk_fail), 64'(e.fail));
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        check("missing_chk_valid", 64'(chk_valid), 64'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; clear = 1'b0;
    {s2, s1, s0} = 3'd0; a = '0; b = '0; ci = 1'b0; z = '0; co = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_chk_valid", 64'(chk_valid), 64'd0);
    check("rst_pass_cnt", 64'(pass_cnt), 64'd0);
    check("rst_fail_cnt", 64'(fail_cnt), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_fail_got", 64'(fail_got), 64'd0);
    rst = 1'b0;
    idle(1, 1'b0);

    // Adder sweep, back to back.
    for (int i = 0; i < 16; i++) ok(3'b011, 4'(i % 4), 4'(i / 4), 1'b0, 1'b0);
    idle(2, 1'b0);
    check("add_pass_cnt", 64'(pass_cnt), 64'd16);
    check("add_fail_cnt", 64'(fail_cnt), 64'd0);
    check("add_err", 64'(err), 64'd0);
    check("add_sat_pass_cnt", 64'(sat_pass_cnt), 64'd3);

    // Subtract: observed values written out literally.
    idle(1, 1'b1);
    check("clear_pass_cnt", 64'(pass_cnt), 64'd0);
    drive(1'b1, 3'b101, 4'h0, 4'h1, 1'b1, 5'h0F, 1'b0);
    drive(1'b1, 3'b101, 4'h5, 4'h3, 1'b1, 5'h12, 1'b0);
    idle(2, 1'b0);
    check("sub_pass_cnt", 64'(pass_cnt), 64'd2);
    check("sub_fail_cnt", 64'(fail_cnt), 64'd0);

    // Two injected mismatches; only the first is captured.
    drive(1'b1, 3'b000, 4'hC, 4'hA, 1'b0, 5'h09, 1'b0);
    drive(1'b1, 3'b001, 4'h1, 4'h2, 1'b0, 5'h00, 1'b0);
    idle(2, 1'b0);
    check("mm_fail_cnt", 64'(fail_cnt), 64'd2);
    check("mm_pass_cnt", 64'(pass_cnt), 64'd2);
    check("mm_err", 64'(err), 64'd1);
    check("mm_fail_op", 64'(fail_op), 64'd0);
    check("mm_fail_a", 64'(fail_a), 64'hC);
    check("mm_fail_b", 64'(fail_b), 64'hA);
    check("mm_fail_ci", 64'(fail_ci), 64'd0);
    check("mm_fail_exp", 64'(fail_exp), 64'h08);
    check("mm_fail_got", 64'(fail_got), 64'h09);

    // Saturation: CW=2 instance stops at 3.
    idle(1, 1'b1);
    for (int i = 0; i < 5; i++) ok(3'b010, 4'(i), 4'(3 * i), 1'b0, 1'b0);
    idle(2, 1'b0);
    check("sat_pass_cnt", 64'(sat_pass_cnt), 64'd3);
    check("wide_pass_cnt", 64'(pass_cnt), 64'd5);
    for (int i = 0; i < 5; i++)
      drive(1'b1, 3'b010, 4'(i), 4'hF, 1'b0, alu_ref(3'b010, 4'(i), 4'hF, 1'b0) ^ 5'h01, 1'b0);
    idle(2, 1'b0);
    check("sat_fail_cnt", 64'(sat_fail_cnt), 64'd3);
    check("sat_pass_hold", 64'(sat_pass_cnt), 64'd3);
    check("wide_fail_cnt", 64'(fail_cnt), 64'd5);
    check("sat_err", 64'(sat_err), 64'd1);
    check("sat_fail_a", 64'(sat_fail_a), 64'd0);

    // Clear lands on the edge a failing comparison completes.
    drive(1'b1, 3'b110, 4'h7, 4'h0, 1'b0, 5'h00, 1'b0);
    ok(3'b100, 4'h3, 4'h0, 1'b0, 1'b1);
    check("clr_chk_fail", 64'(chk_fail), 64'd1);
    check("clr_chk_valid", 64'(chk_valid), 64'd1);
    check("clr_fail_cnt", 64'(fail_cnt), 64'd0);
    check("clr_pass_cnt", 64'(pass_cnt), 64'd0);
    check("clr_err", 64'(err), 64'd0);
    check("clr_fail_got", 64'(fail_got), 64'd0);
    idle(1, 1'b0);
    check("clr_next_pass_cnt", 64'(pass_cnt), 64'd1);
    idle(1, 1'b0);

    // Asynchronous reset with two transactions in flight.
    drive(1'b1, 3'b111, 4'hF, 4'h0, 1'b1, 5'h00, 1'b0);
    ok(3'b011, 4'h2, 4'h2, 1'b0, 1'b0);
    check("pre_rst_err", 64'(err), 64'd1);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    #1;
    check("arst_chk_valid", 64'(chk_valid), 64'd0);
    check("arst_pass_cnt", 64'(pass_cnt), 64'd0);
    check("arst_fail_cnt", 64'(fail_cnt), 64'd0);
    check("arst_err", 64'(err), 64'd0);
    check("arst_fail_exp", 64'(fail_exp), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4, 1'b0);
    ok(3'b111, 4'h9, 4'h0, 1'b1, 1'b0);
    idle(3, 1'b0);
    check("post_rst_pass_cnt", 64'(pass_cnt), 64'd1);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/alu_checker.md
Name: alu_checker

Overview:
- Pipelined response checker for the W-bit `alu` block; it is the receiving end of the ALU stimulus path.
- Each cycle it may sample one transaction: select lines, operands, carry-in and the ALU's observed z/co.
- It computes the golden result internally and compares it against the observed values.
- It keeps pass/fail counters, a sticky error flag and a capture of the first failing transaction, so ALU benches and on-chip self-test check in hardware instead of by waveform.

Parameters:
W, 4, operand/result width (must match the ALU instance).
CW, 16, width of pass/fail counters.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  asynchronous active-high reset.
in_valid  in  1  transaction present on inputs this cycle.
s0  in  1  ALU select bit 0.
s1  in  1  ALU select bit 1.
s2  in  1  ALU select bit 2.
ci  in  1  carry-in applied to ALU.
a  in  W  operand a.
b  in  W  operand b.
z  in  W  observed ALU result.
co  in  1  observed ALU carry-out.
clear  in  1  synchronous clear of counters, sticky flag and capture.
chk_valid  out  1  one-cycle pulse: a comparison completed.
chk_fail  out  1  qualified by chk_valid: that comparison mismatched.
pass_cnt  out  CW  number of matching transactions (saturating).
fail_cnt  out  CW  number of mismatching transactions (saturating).
err  out  1  sticky: at least one mismatch since reset/clear.
fail_op  out  3  {s2,s1,s0} of first failing transaction.
fail_a  out  W  a of first failing transaction.
fail_b  out  W  b of first failing transaction.
fail_ci  out  1  ci of first failing transaction.
fail_exp  out  W+1  expected {co,z} of first failure.
fail_got  out  W+1  observed {co,z} of first failure.

Behaviour:
- Reset (async, rst=1): every register and output goes to 0 immediately, including pipeline valids; in-flight transactions are discarded.
- ALU golden model, op={s2,s1,s0}, all sums in W+1 bits, co = bit W:
  - 000: z=a&b, co=0
  - 001: z=a|b, co=0
  - 010: z=a^b, co=0
  - 011: {co,z}=a+b+ci
  - 100: z=~a, co=0
  - 101: {co,z}=a+~b+ci (subtract when ci=1)
  - 110: z=a, co=0
  - 111: {co,z}=a+ci
- Pipeline, two stages, no backpressure; a transaction is accepted every cycle in_valid=1.
  - Stage 1 (edge after sampling): register op, a, b, ci, z, co, valid.
  - Stage 2 (next edge): register expected value and comparison.
  - chk_valid/chk_fail are asserted exactly 2 cycles after the in_valid cycle.
- Counters and flags, updated in the same edge chk_valid rises:
  - On a match, pass_cnt increments; on a mismatch, fail_cnt increments.
  - Both counters saturate at 2^CW-1 and never wrap.
  - A mismatch sets err, which stays set.
  - The fail_* capture loads only on a mismatch while err=0, so only the first failure is held; later failures leave the capture unchanged.
- clear=1:
  - Zeroes pass_cnt, fail_cnt, err and fail_*.
  - A comparison completing in the same cycle still drives chk_valid/chk_fail but is NOT counted or captured.
  - Stage-1 contents are unaffected and complete normally on the next cycle.
- Back-to-back transactions with in_valid held high give one chk_valid per cycle, with no bubbles.
- in_valid=0 cycles produce chk_valid=0 two cycles later; counters hold.

Test Plan:
- W=4, op=011, ci=0, a=i%4, b=i/4 for i=0..15, in_valid=1 continuously, z/co from a real alu instance -> 16 chk_valid pulses from cycle 2, chk_fail=0, pass_cnt=16, fail_cnt=0, err=0.
- op=101, ci=1: a=0,b=1 must match z=F, co=0; then a=5,b=3 with z=2, co=1 fed -> both pass, pass_cnt=2.
- Inject mismatches: op=000, a=C, b=A, z=9 (expected 8), then op=001 a=1 b=2 z=0 -> fail_cnt=2, err=1, fail_op=000, fail_exp=0x08, fail_got=0x09 (first failure retained).
- CW=2 with 5 passing transactions -> pass_cnt stops at 3; with 5 failing -> fail_cnt stops at 3.
- Assert clear in the cycle a failing comparison completes, with a passing transaction in stage 1 -> chk_valid=1 and chk_fail=1 that cycle; counters 0 and err=0 after it; pass_cnt=1 next cycle.
- Assert rst asynchronously between edges with two transactions in flight -> all outputs 0 immediately; no chk_valid after release until new in_valid, first pulse 2 cycles after it.
